obuf_write_packer: RTL and testbench
====================================

Name: obuf_write_packer

Overview:
- Upstream write-side feeder for the 64K x 128-bit output buffer.
- Accepts a stream of 16-bit result elements from the compute datapath over a valid/ready handshake.
- Packs 8 elements into one 128-bit line and writes each line to sequential buffer addresses through the buffer's single write port (WE, WriteAddress, WriteBus).
- Supports a programmable base address, a word count, zero-padded partial-line flush and a one-cycle completion pulse.

Parameters:
ELEM_W, 16, element width in bits
LANES, 8, elements per line; ELEM_W*LANES must equal 128
ADDR_W, 16, buffer address width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a job when idle
base_addr  input  ADDR_W  first line address, sampled on accepted start
word_count  input  ADDR_W+1  lines to write, sampled on accepted start
in_valid  input  1  element valid
in_data  input  ELEM_W  result element
in_ready  output  1  block can accept an element this cycle
flush  input  1  write the current partial line, zero-padded
WE  output  1  buffer write enable, registered
WriteAddress  output  ADDR_W  buffer write address, registered
WriteBus  output  128  buffer write data, registered
busy  output  1  job in progress
done  output  1  one-cycle pulse after the final line's write cycle

Behaviour:
- Reset (async, reset_n=0): WE=0, WriteAddress=0, WriteBus=0, busy=0, done=0, in_ready=0. State goes to IDLE and lane counter, address and count registers clear. Any in-flight job is abandoned, and WE falls immediately without waiting for a clock edge.
- All buffer-facing outputs come straight from flops, so they are stable before the buffer's 2 ns input delay window.
- States: IDLE, PACK, FINAL.
- IDLE:
  - in_ready=0.
  - On start, latch base_addr into addr, set lane=0 and remaining=min(word_count,65536).
  - If remaining=0: done=1 next cycle, stay IDLE.
  - Otherwise go to PACK with busy=1.
- PACK:
  - in_ready=1.
  - An element is accepted on a rising edge with in_valid&in_ready.
  - Element at lane n goes to bits [16n+15:16n]; lane 0 holds the LSBs. Then lane increments.
  - Line completion (accept at lane=7, or flush with lane>0): at that same edge WE<=1, WriteAddress<=addr, WriteBus<=packed line with unfilled lanes set to 0. Also addr<=addr+1 mod 2^16 (wraps 0xFFFF->0x0000), lane<=0, remaining<=remaining-1.
  - WE is high for exactly one cycle per line. It drops at the next edge unless another line completes.
  - Throughput is one element per clock. Back-to-back lines give WE high on consecutive lines with no bubble.
  - If the completed line was the last (remaining was 1), state<=FINAL and in_ready drops for the next cycle.
- flush:
  - Counts as a line toward word_count.
  - flush with lane=0 is ignored: no write, no count change.
  - flush and an accepted element in the same cycle: the element is packed first, then padding is applied. If that element fills lane 7, only one line is written.
- FINAL:
  - in_ready=0.
  - At the next edge WE<=0, done<=1, busy<=0, state<=IDLE.
- done is high for one cycle, the cycle after the final WE cycle.
- start while busy is ignored, and base_addr/word_count are not re-sampled.
- in_data is ignored whenever in_ready=0.

Test Plan:
- Reset, start base=0x0010 count=2, then 16 elements 0x0001..0x0010 with in_valid held high -> WE pulses at 0x0010 with WriteBus=0x0008_0007_0006_0005_0004_0003_0002_0001, and at 0x0011 with 0x0010..0x0009. Lines are consecutive; done one cycle after the second WE; busy low with done.
- base=0xFFFF count=2, 16 elements -> writes to 0xFFFF then 0x0000 (wrap); done asserted.
- count=1, 3 elements 0xAAAA,0xBBBB,0xCCCC then flush -> one write, WriteBus=0x...0000_CCCC_BBBB_AAAA with upper 80 bits zero; done follows.
- flush with lane=0, and flush together with the 8th element -> no extra WE; exactly one WE for the full line.
- in_valid toggling randomly for 8 elements, plus start pulsed mid-job -> same packed data as the back-to-back case; start ignored; WriteAddress unchanged by the stray start.
- reset_n asserted while WE=1 mid-job -> WE, busy and in_ready fall without a clock edge. After release, a new job with count=1 and 8 elements writes correctly from its own base.
- count=0 -> no WE; done pulses one cycle after start.

Source files
------------

// File: rtl/obuf_write_packer_if.sv
// Handshake and buffer write-port bundle between the result stream feeder and
// the output-buffer write packer.
interface obuf_write_packer_if #(
  parameter int ELEM_W = 16,
  parameter int LANES  = 8,
  parameter int ADDR_W = 16
);
  logic                      start;
  logic [ADDR_W-1:0]         base_addr;
  logic [ADDR_W:0]           word_count;
  logic                      in_valid;
  logic [ELEM_W-1:0]         in_data;
  logic                      in_ready;
  logic                      flush;
  logic                      WE;
  logic [ADDR_W-1:0]         WriteAddress;
  logic [ELEM_W*LANES-1:0]   WriteBus;
  logic                      busy;
  logic                      done;

  modport master (
    output start, base_addr, word_count, in_valid, in_data, flush,
    input  in_ready, WE, WriteAddress, WriteBus, busy, done
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_data, flush,
    output in_ready, WE, WriteAddress, WriteBus, busy, done
  );
endinterface

// File: rtl/obuf_write_packer.sv
// Packs 16-bit result elements into 128-bit lines and writes them to
// sequential output-buffer addresses, with zero-padded flush and done pulse.
module obuf_write_packer #(
  parameter int ELEM_W = 16,
  parameter int LANES  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  obuf_write_packer_if.slave  bus
);
  localparam int LINE_W = ELEM_W * LANES;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [ADDR_W:0]   MAX_LINES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_LINE  = (ADDR_W+1)'(1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, PACK, FINAL} state_t;

  state_t              r_state,     w_state_nxt;
  logic [LANE_W-1:0]   r_lane,      w_lane_nxt;
  logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
  logic [ADDR_W:0]     r_remaining, w_remaining_nxt;
  logic [LINE_W-1:0]   r_line,      w_line_nxt;
  logic                r_we,        w_we_nxt;
  logic [ADDR_W-1:0]   r_waddr,     w_waddr_nxt;
  logic [LINE_W-1:0]   r_wbus,      w_wbus_nxt;
  logic                r_done,      w_done_nxt;

  logic                w_accept;
  logic                w_line_done;
  logic [LINE_W-1:0]   w_merged;
  logic [LANE_W:0]     w_fill;
  logic [ADDR_W:0]     w_count;

  function automatic logic [LINE_W-1:0] pad_line(input logic [LINE_W-1:0] line,
                                                 input logic [LANE_W:0]   fill);
    logic [LINE_W-1:0] padded;
    padded = line;
    for (int i = 0; i < LANES; i++) begin
      if (i >= int'(fill)) padded[i*ELEM_W +: ELEM_W] = '0;
    end
    return padded;
  endfunction

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] cnt);
    return (cnt > MAX_LINES) ? MAX_LINES : cnt;
  endfunction

  // Element merge: the incoming element lands in its lane before any flush padding
  always_comb begin
    w_accept = (r_state == PACK) && bus.in_valid;
    w_merged = r_line;
    if (w_accept) w_merged[int'(r_lane)*ELEM_W +: ELEM_W] = bus.in_data;
    w_fill      = {1'b0, r_lane} + {{LANE_W{1'b0}}, w_accept};
    w_line_done = (w_accept && (r_lane == LAST_LANE)) ||
                  ((r_state == PACK) && bus.flush && ((r_lane != '0) || w_accept));
    w_count     = clamp_count(bus.word_count);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lane_nxt      = r_lane;
    w_addr_nxt      = r_addr;
    w_remaining_nxt = r_remaining;
    w_line_nxt      = r_line;
    w_we_nxt        = 1'b0;
    w_waddr_nxt     = r_waddr;
    w_wbus_nxt      = r_wbus;
    w_done_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_addr_nxt      = bus.base_addr;
          w_lane_nxt      = '0;
          w_line_nxt      = '0;
          w_remaining_nxt = w_count;
          if (w_count == '0) w_done_nxt  = 1'b1;
          else               w_state_nxt = PACK;
        end
      end
      PACK: begin
        if (w_line_done) begin
          w_we_nxt        = 1'b1;
          w_waddr_nxt     = r_addr;
          w_wbus_nxt      = pad_line(w_merged, w_fill);
          w_addr_nxt      = r_addr + 1'b1;
          w_lane_nxt      = '0;
          w_line_nxt      = '0;
          w_remaining_nxt = r_remaining - ONE_LINE;
          if (r_remaining == ONE_LINE) w_state_nxt = FINAL;
        end else if (w_accept) begin
          w_lane_nxt = r_lane + 1'b1;
          w_line_nxt = w_merged;
        end
      end
      FINAL: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Register stage: every buffer-facing output is driven straight from these flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_lane      <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_line      <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wbus      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane      <= w_lane_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_line      <= w_line_nxt;
      r_we        <= w_we_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wbus      <= w_wbus_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.in_ready     = (r_state == PACK);
  assign bus.busy         = (r_state != IDLE);
  assign bus.WE           = r_we;
  assign bus.WriteAddress = r_waddr;
  assign bus.WriteBus     = r_wbus;
  assign bus.done         = r_done;
endmodule

// File: tb/tb_obuf_write_packer.sv
// Directed bench for obuf_write_packer: queue-based line model checked every
// cycle, plus literal expectations on the recorded buffer writes.
module tb_obuf_write_packer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  obuf_write_packer_if bus();

  obuf_write_packer dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural model: collect accepted elements, emit a line when 8 are held
  // or a flush arrives with at least one element.
  logic         m_we, m_done, m_busy, m_ready, m_final;
  logic [15:0]  m_waddr, m_addr;
  logic [127:0] m_wbus;
  int           m_rem;
  logic [15:0]  m_q[$];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_we = 0; m_done = 0; m_busy = 0; m_ready = 0; m_final = 0;
      m_waddr = 0; m_addr = 0; m_wbus = 0; m_rem = 0;
      m_q.delete();
    end else begin
      logic acc;
      logic nwe, ndone;
      logic [127:0] line;
      acc = m_ready && bus.in_valid;
      nwe = 0; ndone = 0;
      if (!m_busy) begin
        if (bus.start) begin
          m_addr = bus.base_addr;
          m_q.delete();
          m_rem = (int'(bus.word_count) > 65536) ? 65536 : int'(bus.word_count);
          if (m_rem == 0) ndone = 1;
          else begin m_busy = 1; m_ready = 1; end
        end
      end else if (m_final) begin
        m_busy = 0; m_final = 0; ndone = 1;
      end else begin
        if (acc) m_q.push_back(bus.in_data);
        if (m_q.size() == 8 || (bus.flush && m_q.size() > 0)) begin
          line = '0;
          foreach (m_q[i]) line = line | (128'(m_q[i]) << (16 * i));
          nwe = 1;
          m_waddr = m_addr;
          m_wbus = line;
          m_addr = 16'((int'(m_addr) + 1) % 65536);
          m_q.delete();
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_final = 1; m_ready = 0; end
        end
      end
      m_we = nwe;
      m_done = ndone;
    end
  end

  always @(negedge clock) begin
    chk("cyc_WE", 128'(bus.WE), 128'(m_we));
    chk("cyc_WriteAddress", 128'(bus.WriteAddress), 128'(m_waddr));
    chk("cyc_WriteBus", bus.WriteBus, m_wbus);
    chk("cyc_done", 128'(bus.done), 128'(m_done));
    chk("cyc_busy", 128'(bus.busy), 128'(m_busy));
    chk("cyc_in_ready", 128'(bus.in_ready), 128'(m_ready));
  end

  // Record every buffer write seen on the port
  logic [15:0]  wr_addr[$];
  logic [127:0] wr_data[$];
  int           wr_cyc[$];
  always @(negedge clock) begin
    if (reset_n && bus.WE) begin
      wr_addr.push_back(bus.WriteAddress);
      wr_data.push_back(bus.WriteBus);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic start_job(input logic [15:0] base, input logic [16:0] count);
    bus.start = 1; bus.base_addr = base; bus.word_count = count;
    tick();
    bus.start = 0;
  endtask

  task automatic send(input logic [15:0] d, input logic fl);
    int guard;
    guard = 0;
    bus.in_valid = 1; bus.in_data = d; bus.flush = fl;
    while (!bus.in_ready && guard < 50) begin tick(); guard++; end
    if (guard >= 50) chk("send_timeout", 128'(guard), 128'(0));
    tick();
    bus.in_valid = 0; bus.flush = 0;
  endtask

  task automatic do_flush();
    bus.flush = 1; bus.in_valid = 0;
    tick();
    bus.flush = 0;
  endtask

  int done_at;
  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    done_at = -1;
    while (guard < 100) begin
      tick(); guard++;
      if (bus.done) begin done_at = cyc; break; end
    end
    if (done_at < 0) chk({name, "_done_timeout"}, 128'(guard), 128'(0));
    else chk({name, "_busy_at_done"}, 128'(bus.busy), 128'(0));
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [15:0] a, input logic [127:0] d);
    if (wr_addr.size() > idx) begin
      chk({name, "_addr"}, 128'(wr_addr[idx]), 128'(a));
      chk({name, "_data"}, wr_data[idx], d);
    end else chk({name, "_missing"}, 128'(wr_addr.size()), 128'(idx + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.base_addr = 0; bus.word_count = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.flush = 0;
    reset_n = 0;
    repeat (2) tick();
    chk("rst_WE", 128'(bus.WE), 128'(0));
    chk("rst_WriteAddress", 128'(bus.WriteAddress), 128'(0));
    chk("rst_WriteBus", bus.WriteBus, 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    reset_n = 1;
    tick();

    // Two back-to-back lines from 0x0010
    clear_log();
    start_job(16'h0010, 17'd2);
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b0);
    wait_done("t1");
    chk("t1_nwrites", 128'(wr_addr.size()), 128'(2));
    chk_wr("t1_w0", 0, 16'h0010, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk_wr("t1_w1", 1, 16'h0011, 128'h0010_000f_000e_000d_000c_000b_000a_0009);
    if (wr_cyc.size() == 2) chk("t1_done_cycle", 128'(done_at), 128'(wr_cyc[1] + 1));
    else chk("t1_done_cycle_nwrites", 128'(wr_cyc.size()), 128'(2));
    repeat (2) tick();

    // Address wrap 0xFFFF -> 0x0000
    clear_log();
    start_job(16'hFFFF, 17'd2);
    for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), 1'b0);
    wait_done("t2");
    chk("t2_nwrites", 128'(wr_addr.size()), 128'(2));
    chk_wr("t2_w0", 0, 16'hFFFF, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk_wr("t2_w1", 1, 16'h0000, 128'h010f_010e_010d_010c_010b_010a_0109_0108);
    repeat (2) tick();

    // Partial line flush, zero padded
    clear_log();
    start_job(16'h0200, 17'd1);
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    send(16'hCCCC, 1'b0);
    do_flush();
    wait_done("t3");
    chk("t3_nwrites", 128'(wr_addr.size()), 128'(1));
    chk_wr("t3_w0", 0, 16'h0200, 128'h0000_0000_0000_0000_0000_cccc_bbbb_aaaa);
    repeat (2) tick();

    // Flush at lane 0 ignored; flush with the 8th element writes once
    clear_log();
    start_job(16'h0300, 17'd1);
    do_flush();
    chk("t4_no_we_after_empty_flush", 128'(bus.WE), 128'(0));
    for (int i = 0; i < 7; i++) send(16'h3000 + 16'(i), 1'b0);
    send(16'h3007, 1'b1);
    wait_done("t4");
    chk("t4_nwrites", 128'(wr_addr.size()), 128'(1));
    chk_wr("t4_w0", 0, 16'h0300, 128'h3007_3006_3005_3004_3003_3002_3001_3000);
    repeat (2) tick();

    // Gappy in_valid with a stray start mid-job
    clear_log();
    start_job(16'h0400, 17'd1);
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      bus.in_valid = 0;
      bus.in_data = 16'hDEAD;
      repeat (gap) tick();
      if (i == 3) begin
        bus.start = 1; bus.base_addr = 16'h7777; bus.word_count = 17'd5;
        tick();
        bus.start = 0;
      end
      send(16'(i + 1), 1'b0);
    end
    wait_done("t5");
    repeat (4) tick();
    chk("t5_nwrites", 128'(wr_addr.size()), 128'(1));
    chk_wr("t5_w0", 0, 16'h0400, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t5_idle_after", 128'(bus.busy), 128'(0));

    // Asynchronous reset while WE is high
    clear_log();
    start_job(16'h0500, 17'd2);
    for (int i = 0; i < 8; i++) send(16'h5000 + 16'(i), 1'b0);
    chk("t6_we_before_reset", 128'(bus.WE), 128'(1));
    #2;
    reset_n = 0;
    #1;
    chk("t6_we_async", 128'(bus.WE), 128'(0));
    chk("t6_busy_async", 128'(bus.busy), 128'(0));
    chk("t6_ready_async", 128'(bus.in_ready), 128'(0));
    @(posedge clock);
    #1;
    reset_n = 1;
    tick();
    clear_log();
    start_job(16'h0600, 17'd1);
    for (int i = 0; i < 8; i++) send(16'h6000 + 16'(i), 1'b0);
    wait_done("t6");
    chk("t6_nwrites", 128'(wr_addr.size()), 128'(1));
    chk_wr("t6_w0", 0, 16'h0600, 128'h6007_6006_6005_6004_6003_6002_6001_6000);
    repeat (2) tick();

    // Zero-length job
    clear_log();
    start_job(16'h0700, 17'd0);
    chk("t7_done", 128'(bus.done), 128'(1));
    chk("t7_busy", 128'(bus.busy), 128'(0));
    tick();
    chk("t7_done_drop", 128'(bus.done), 128'(0));
    repeat (2) tick();
    chk("t7_nwrites", 128'(wr_addr.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
